pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter controller that sequences the 8-bit instruction ROM/decoder. It owns `pc`, steps through the program one instruction per cycle, and resolves JMP/BNE/BEQ/BLT using the decoder's `jmpLoc` and the ALU compare flags. It stalls on LB/STR until memory acknowledges, and stops on HALT, program overrun or memory timeout. It sits between the top-level start/done handshake and the instr_rom / register file / data memory.

## Interface
- `PROG_LEN`, 16'd26: number of valid ROM words. Reaching `pc == PROG_LEN` without HALT is a fault.
- `MEM_TIMEOUT`, 8'd16: maximum wait cycles for `mem_ack` on LB/STR.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `start`  in  1  begin execution at pc 0. Honoured only in IDLE or HALTED.
- `opcode`  in  4  decoder opcode for the current `pc`.
- `jmpLoc`  in  16  decoder branch/jump target for the current `pc`.
- `eq_flag`  in  1  ALU: operands equal.
- `lt_flag`  in  1  ALU: operand1 < operand2.
- `mem_ack`  in  1  data memory completed the current LB/STR.
- `pc`  out  16  registered program counter.
- `reg_we`  out  1  register-file write strobe, combinational.
- `mem_re`  out  1  data-memory read request, combinational.
- `mem_we`  out  1  data-memory write request, combinational.
- `busy`  out  1  registered; high in RUN and MEM.
- `done`  out  1  registered; high in HALTED.
- `fault`  out  1  registered; overrun or timeout. Cleared by the next accepted `start` or by reset.
- `instr_count`  out  16  registered; retired instructions, saturates at 16'hFFFF.

## Operation
- States:
  - IDLE: after reset.
  - RUN: one instruction per cycle.
  - MEM: waiting for `mem_ack`.
  - HALTED.
- Reset: state=IDLE; `pc`=0, `busy`=0, `done`=0, `fault`=0, `instr_count`=0, `reg_we`=`mem_re`=`mem_we`=0.
- Reset mid-operation behaves identically. An in-flight memory request is dropped.
- IDLE/HALTED + `start`: `pc`←0, `instr_count`←0, `fault`←0, `done`←0, go to RUN.
- RUN, by `opcode`:
  - LHB(1), LIM(4), MVB(5), MVF(6), ADD(7), SUB(8), SFT(9), INC(D): `reg_we`=1, `pc`←`pc`+1.
  - JMP(2): `pc`←`jmpLoc`.
  - BNE(A): taken if !`eq_flag`. BEQ(B): taken if `eq_flag`. BLT(C): taken if `lt_flag`.
  - Branch taken: `pc`←`jmpLoc`. Not taken: `pc`←`pc`+1. No `reg_we`.
  - TBA(F): NOP, `pc`←`pc`+1.
  - HALT(E): go to HALTED, `done`←1, `pc` held at the HALT address.
  - LB(0): `mem_re`=1. STR(3): `mem_we`=1.
    - If `mem_ack` is high in the same cycle: complete (LB also asserts `reg_we`), `pc`←`pc`+1.
    - Otherwise go to MEM and clear the wait counter.
- MEM:
  - Hold `pc`. Keep asserting `mem_re`/`mem_we` for the pending op. The wait counter increments each cycle.
  - On `mem_ack`: complete as above and return to RUN.
  - If the counter reaches `MEM_TIMEOUT` without ack: deassert requests, `fault`←1, go to HALTED, `done`←1.
- Overrun: any RUN→RUN update producing `pc` ≥ `PROG_LEN` (including a jump target) goes to HALTED with `fault`←1 and `done`←1. `pc` takes the new value.
- `instr_count` increments on every retiring instruction: each RUN cycle not entering MEM, each MEM ack, and HALT itself.
- `pc` arithmetic is 16-bit modulo. 16'hFFFF+1 = 0, but the overrun check fires first whenever `PROG_LEN` ≤ 16'hFFFF.
- `start` during RUN/MEM is ignored.
- `reg_we`/`mem_re`/`mem_we` are 0 in IDLE and HALTED regardless of `opcode`.

## Timing
- Non-memory instruction: latency 1 cycle. `pc` shows the next address on the edge after the instruction is presented.
- LB/STR: 1 + N cycles, where N = cycles until `mem_ack`. `reg_we` for LB is asserted in the cycle `mem_ack` is sampled high.
- Timeout: HALTED is entered on the edge where the wait counter equals `MEM_TIMEOUT`, i.e. `MEM_TIMEOUT`+1 cycles after the request was first asserted.
- Branch/jump: no bubble. Target fetched in the next cycle.
- `start` to first instruction: 1 cycle (RUN is entered with `pc`=0).
- `done`/`fault`/`busy` change on the same edge as the state transition.

## Test plan
- Reset, then `start`: `pc`=0, `busy`=1. Feed ADD, LIM, SUB: `pc` goes 1, 2, 3; `reg_we`=1 each cycle; `instr_count`=3.
- BNE at pc 12 with `jmpLoc`=10: `eq_flag`=0 → `pc`=10. `eq_flag`=1 → `pc`=13. Repeat both cases for BEQ and BLT with the matching flags.
- LB at pc 1 with `mem_ack` after 3 cycles: `mem_re` high 4 cycles, `pc` holds 1, then `reg_we`=1 and `pc`=2. STR with same-cycle ack completes in 1 cycle with no `reg_we`.
- STR with no ack, `MEM_TIMEOUT`=16: after 17 cycles `fault`=1, `done`=1, `mem_we`=0, `pc` unchanged. Next `start` clears `fault` and sets `pc`=0.
- HALT at pc 25: `done`=1, `pc`=25, strobes 0, `start` ignored while busy. With no HALT, `pc`→26 sets `fault`=1. A JMP to 16'h0030 also faults.
- Assert `rst_n`=0 while in MEM: next edge all outputs return to reset values and state is IDLE.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 8-bit instruction ROM/decoder.
// Steps pc, resolves branches, stalls on memory ops, halts on faults.
module pc_sequencer #(
  parameter logic [15:0] PROG_LEN    = 16'd26,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] jmpLoc,
  input  logic        eq_flag,
  input  logic        lt_flag,
  input  logic        mem_ack,
  output logic [15:0] pc,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] instr_count
);

  localparam logic [3:0] OP_LB   = 4'h0;
  localparam logic [3:0] OP_LHB  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_LIM  = 4'h4;
  localparam logic [3:0] OP_MVB  = 4'h5;
  localparam logic [3:0] OP_MVF  = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_SFT  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BLT  = 4'hC;
  localparam logic [3:0] OP_INC  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_TBA  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MEM,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nx;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nx;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_nx;
  logic [7:0]  w_wait_inc;
  logic        r_fault;
  logic        w_fault_nx;
  logic        r_st;
  logic        w_st_nx;
  logic        w_reg_we;
  logic        w_mem_re;
  logic        w_mem_we;
  logic        w_adv;
  logic [15:0] w_tgt;
  logic [15:0] w_pc_inc;

  assign w_pc_inc   = r_pc + 16'd1;
  assign w_wait_inc = r_wait + 8'd1;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= 16'd0;
      r_cnt   <= 16'd0;
      r_wait  <= 8'd0;
      r_fault <= 1'b0;
      r_st    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_cnt   <= w_cnt_nx;
      r_wait  <= w_wait_nx;
      r_fault <= w_fault_nx;
      r_st    <= w_st_nx;
    end
  end

  // Next-state, pc update and strobe decode
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_cnt_nx   = r_cnt;
    w_wait_nx  = r_wait;
    w_fault_nx = r_fault;
    w_st_nx    = r_st;
    w_reg_we   = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_adv      = 1'b0;
    w_tgt      = w_pc_inc;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_pc_nx    = 16'd0;
          w_cnt_nx   = 16'd0;
          w_fault_nx = 1'b0;
        end
      end
      S_RUN: begin
        unique case (opcode)
          OP_LB, OP_STR: begin
            w_mem_re = (opcode == OP_LB);
            w_mem_we = (opcode == OP_STR);
            if (mem_ack) begin
              w_reg_we = (opcode == OP_LB);
              w_adv    = 1'b1;
            end else begin
              w_state_nx = S_MEM;
              w_wait_nx  = 8'd0;
              w_st_nx    = (opcode == OP_STR);
            end
          end
          OP_JMP: begin
            w_tgt = jmpLoc;
            w_adv = 1'b1;
          end
          OP_BNE: begin
            w_tgt = !eq_flag ? jmpLoc : w_pc_inc;
            w_adv = 1'b1;
          end
          OP_BEQ: begin
            w_tgt = eq_flag ? jmpLoc : w_pc_inc;
            w_adv = 1'b1;
          end
          OP_BLT: begin
            w_tgt = lt_flag ? jmpLoc : w_pc_inc;
            w_adv = 1'b1;
          end
          OP_HALT: begin
            w_state_nx = S_HALT;
            if (r_cnt != 16'hFFFF) w_cnt_nx = r_cnt + 16'd1;
          end
          OP_TBA: w_adv = 1'b1;
          OP_LHB, OP_LIM, OP_MVB, OP_MVF,
          OP_ADD, OP_SUB, OP_SFT, OP_INC: begin
            w_reg_we = 1'b1;
            w_adv    = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        w_mem_re = !r_st;
        w_mem_we = r_st;
        if (mem_ack) begin
          w_reg_we = !r_st;
          w_adv    = 1'b1;
        end else begin
          w_wait_nx = w_wait_inc;
          if (w_wait_inc >= MEM_TIMEOUT) begin
            w_state_nx = S_HALT;
            w_fault_nx = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (w_adv) begin
      w_pc_nx = w_tgt;
      if (r_cnt != 16'hFFFF) w_cnt_nx = r_cnt + 16'd1;
      if (w_tgt >= PROG_LEN) begin
        w_state_nx = S_HALT;
        w_fault_nx = 1'b1;
      end else begin
        w_state_nx = S_RUN;
      end
    end
  end

  assign pc          = r_pc;
  assign instr_count = r_cnt;
  assign fault       = r_fault;
  assign busy        = (r_state == S_RUN) || (r_state == S_MEM);
  assign done        = (r_state == S_HALT);
  assign reg_we      = w_reg_we;
  assign mem_re      = w_mem_re;
  assign mem_we      = w_mem_we;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table,
// multi-cycle corner sequences and randomized model compare.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] jmpLoc;
  logic        eq_flag;
  logic        lt_flag;
  logic        mem_ack;
  logic [15:0] pc;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] instr_count;

  int checks;
  int failures;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .jmpLoc      (jmpLoc),
    .eq_flag     (eq_flag),
    .lt_flag     (lt_flag),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .reg_we      (reg_we),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] jl;
    logic        eq;
    logic        lt;
    logic        ack;
    logic        st;
    logic [15:0] epc;
    logic        erw;
    logic        ere;
    logic        ewe;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  task automatic add(input logic [3:0] op,
                     input logic [15:0] jl,
                     input logic eq, input logic lt,
                     input logic ack, input logic st,
                     input logic [15:0] epc,
                     input logic erw, input logic ere,
                     input logic ewe);
    vec_t v;
    v.op = op; v.jl = jl; v.eq = eq; v.lt = lt;
    v.ack = ack; v.st = st; v.epc = epc;
    v.erw = erw; v.ere = ere; v.ewe = ewe;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [15:0] jl,
                       input logic ack);
    opcode  = op;
    jmpLoc  = jl;
    mem_ack = ack;
    eq_flag = 1'b0;
    lt_flag = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [15:0] jl);
    @(negedge clk);
    drive(op, jl, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    @(negedge clk);
    drive(4'h7, 16'd0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // reference model state
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_MEM  = 2;
  localparam int M_HALT = 3;
  int          mm;
  logic [15:0] mpc;
  logic [15:0] mcnt;
  logic        mfault;
  logic        mst;
  int          mwait;

  function automatic logic is_alu(input logic [3:0] op);
    return op inside {4'h1, 4'h4, 4'h5, 4'h6,
                      4'h7, 4'h8, 4'h9, 4'hD};
  endfunction

  task automatic m_retire(input int nxt);
    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    mpc = 16'(nxt);
    if (nxt >= 26) begin
      mm     = M_HALT;
      mfault = 1'b1;
    end else begin
      mm = M_RUN;
    end
  endtask

  task automatic m_step;
    int nxt;
    nxt = (int'(mpc) + 1) % 65536;
    if (!rst_n) begin
      mm = M_IDLE; mpc = 0; mcnt = 0; mfault = 0;
    end else if (mm == M_IDLE || mm == M_HALT) begin
      if (start) begin
        mm = M_RUN; mpc = 0; mcnt = 0; mfault = 0;
      end
    end else if (mm == M_RUN) begin
      if (opcode == 4'hE) begin
        mm = M_HALT;
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end else if ((opcode == 4'h0 || opcode == 4'h3)
                   && !mem_ack) begin
        mm = M_MEM; mwait = 0; mst = (opcode == 4'h3);
      end else begin
        if (opcode == 4'h2) nxt = int'(jmpLoc);
        if (opcode == 4'hA && !eq_flag) nxt = int'(jmpLoc);
        if (opcode == 4'hB && eq_flag) nxt = int'(jmpLoc);
        if (opcode == 4'hC && lt_flag) nxt = int'(jmpLoc);
        m_retire(nxt);
      end
    end else begin
      if (mem_ack) begin
        m_retire(nxt);
      end else begin
        mwait++;
        if (mwait == 16) begin
          mm = M_HALT; mfault = 1'b1;
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    drive(4'h7, 16'd0, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    chk("rst_rw", 32'(reg_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_start();
    chk("start_pc", 32'(pc), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);

    add(4'h7, 16'd0,  L, L, L, L, 16'd1,  H, L, L);
    add(4'h4, 16'd0,  L, L, L, L, 16'd2,  H, L, L);
    add(4'h8, 16'd0,  L, L, L, L, 16'd3,  H, L, L);
    add(4'h2, 16'd12, L, L, L, L, 16'd12, L, L, L);
    add(4'hA, 16'd10, L, L, L, L, 16'd10, L, L, L);
    add(4'h2, 16'd12, L, L, L, L, 16'd12, L, L, L);
    add(4'hA, 16'd10, H, L, L, L, 16'd13, L, L, L);
    add(4'h2, 16'd12, L, L, L, L, 16'd12, L, L, L);
    add(4'hB, 16'd10, H, L, L, L, 16'd10, L, L, L);
    add(4'h2, 16'd12, L, L, L, L, 16'd12, L, L, L);
    add(4'hB, 16'd10, L, H, L, L, 16'd13, L, L, L);
    add(4'h2, 16'd12, L, L, L, L, 16'd12, L, L, L);
    add(4'hC, 16'd10, H, H, L, L, 16'd10, L, L, L);
    add(4'h2, 16'd12, L, L, L, L, 16'd12, L, L, L);
    add(4'hC, 16'd10, H, L, L, L, 16'd13, L, L, L);
    add(4'hF, 16'd3,  L, L, L, L, 16'd14, L, L, L);
    add(4'h3, 16'd0,  L, L, H, L, 16'd15, L, L, H);
    add(4'h0, 16'd0,  L, L, H, L, 16'd16, H, H, L);
    add(4'hD, 16'd0,  L, L, L, H, 16'd17, H, L, L);
    add(4'h2, 16'd1,  L, L, L, L, 16'd1,  L, L, L);

    foreach (tbl[i]) begin
      @(negedge clk);
      opcode  = tbl[i].op;
      jmpLoc  = tbl[i].jl;
      eq_flag = tbl[i].eq;
      lt_flag = tbl[i].lt;
      mem_ack = tbl[i].ack;
      start   = tbl[i].st;
      #1;
      chk($sformatf("v%0d_rw", i), 32'(reg_we), 32'(tbl[i].erw));
      chk($sformatf("v%0d_re", i), 32'(mem_re), 32'(tbl[i].ere));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].ewe));
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tbl[i].epc));
      chk($sformatf("v%0d_cnt", i), 32'(instr_count), 32'(i + 1));
    end

    // LB at pc 1, ack in the fourth request cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(4'h0, 16'd0, k == 3);
      #1;
      chk("lb_re", 32'(mem_re), 32'd1);
      chk("lb_rw", 32'(reg_we), 32'(k == 3));
      @(posedge clk);
      #1;
      chk("lb_pc", 32'(pc), (k == 3) ? 32'd2 : 32'd1);
    end
    chk("lb_cnt", 32'(instr_count), 32'd21);

    // HALT at pc 25
    run_op(4'h2, 16'd25);
    chk("j25_pc", 32'(pc), 32'd25);
    run_op(4'hE, 16'd0);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pc), 32'd25);
    chk("halt_fault", 32'(fault), 32'd0);
    chk("halt_cnt", 32'(instr_count), 32'd23);
    @(negedge clk);
    drive(4'h0, 16'd0, 1'b0);
    #1;
    chk("halt_re", 32'(mem_re), 32'd0);
    opcode = 4'h7;
    #1;
    chk("halt_rw", 32'(reg_we), 32'd0);

    // STR timeout
    do_start();
    chk("rs_pc", 32'(pc), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_cnt", 32'(instr_count), 32'd0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      drive(4'h3, 16'd0, 1'b0);
      #1;
      chk("to_we", 32'(mem_we), 32'd1);
      @(posedge clk);
      #1;
      chk("to_fault", 32'(fault), 32'(k == 16));
      chk("to_done", 32'(done), 32'(k == 16));
    end
    chk("to_pc", 32'(pc), 32'd0);
    chk("to_we_off", 32'(mem_we), 32'd0);
    do_start();
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_pc", 32'(pc), 32'd0);

    // overrun by increment and by jump target
    run_op(4'h2, 16'd25);
    run_op(4'h7, 16'd0);
    chk("ovr_pc", 32'(pc), 32'd26);
    chk("ovr_fault", 32'(fault), 32'd1);
    chk("ovr_done", 32'(done), 32'd1);
    do_start();
    run_op(4'h2, 16'h0030);
    chk("jovr_pc", 32'(pc), 32'h30);
    chk("jovr_fault", 32'(fault), 32'd1);

    // reset while waiting on memory
    do_start();
    run_op(4'h7, 16'd0);
    run_op(4'h0, 16'd0);
    chk("mem_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_pc", 32'(pc), 32'd0);
    chk("mrst_cnt", 32'(instr_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_re", 32'(mem_re), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_idle_re", 32'(mem_re), 32'd0);

    // randomized run against the reference model
    mm = M_IDLE; mpc = 0; mcnt = 0;
    mfault = 0; mst = 0; mwait = 0;
    for (int i = 0; i < 3000; i++) begin
      logic erw, ere, ewe;
      @(negedge clk);
      rst_n   = ($urandom_range(0, 199) != 0);
      start   = ($urandom_range(0, 7) == 0);
      opcode  = 4'($urandom_range(0, 15));
      jmpLoc  = ($urandom_range(0, 15) == 0) ?
                16'($urandom) : 16'($urandom_range(0, 27));
      eq_flag = 1'($urandom_range(0, 1));
      lt_flag = 1'($urandom_range(0, 1));
      mem_ack = ($urandom_range(0, 3) == 0);
      #1;
      erw = 1'b0; ere = 1'b0; ewe = 1'b0;
      if (mm == M_RUN) begin
        ere = (opcode == 4'h0);
        ewe = (opcode == 4'h3);
        erw = is_alu(opcode) || (opcode == 4'h0 && mem_ack);
      end else if (mm == M_MEM) begin
        ere = !mst;
        ewe = mst;
        erw = mem_ack && !mst;
      end
      chk("r_rw", 32'(reg_we), 32'(erw));
      chk("r_re", 32'(mem_re), 32'(ere));
      chk("r_we", 32'(mem_we), 32'(ewe));
      m_step();
      @(posedge clk);
      #1;
      chk("r_pc", 32'(pc), 32'(mpc));
      chk("r_cnt", 32'(instr_count), 32'(mcnt));
      chk("r_fault", 32'(fault), 32'(mfault));
      chk("r_busy", 32'(busy),
          32'(mm == M_RUN || mm == M_MEM));
      chk("r_done", 32'(done), 32'(mm == M_HALT));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
